pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the five-stage CPU (pc_reg, if_id, id_ex, ex_mem, mem_wb). It merges stall requests from the decode stage (load-use) and the execute stage (multi-cycle ALU ops), plus flush requests, into one per-stage stall vector and a flush strobe with redirect PC. It tracks outstanding multi-cycle execute operations with a watchdog and counts stall cycles for performance monitoring. It is instantiated in `cpu` beside the pipeline registers, and each pipeline register consumes its stall bit.

## Interface
- `MAX_EX_CYCLES`, default 64: watchdog limit, in cycles, for one multi-cycle execute operation. Legal range 2..65535.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `stallreq_id`  input  1  decode-stage hazard request, level, combinational.
- `ex_start`  input  1  one-cycle pulse: execute stage has begun a multi-cycle operation.
- `ex_done`  input  1  one-cycle pulse: the multi-cycle result is valid this cycle.
- `flush_req`  input  1  one-cycle pulse: discard in-flight instructions and redirect fetch.
- `flush_pc`  input  32  redirect target; qualified by `flush_req`.
- `cnt_clr`  input  1  synchronous clear of `stall_cnt`.
- `stall`  output  6  per-stage hold vector: bit0 pc, bit1 if_id, bit2 id_ex input (decode), bit3 ex, bit4 mem, bit5 wb.
- `flush`  output  1  flush strobe to all pipeline registers.
- `new_pc`  output  32  redirect PC for pc_reg; `flush_pc` when `flush`=1, else 0.
- `ex_abort`  output  1  one-cycle pulse: the execute stage must drop its multi-cycle operation.
- `ex_timeout`  output  1  sticky error: the watchdog expired.
- `stall_cnt`  output  32  number of cycles with `stall[0]`=1; saturating.

## Operation
- Internal state:
  - FSM `{RUN, EX_WAIT}`.
  - 16-bit `wait_cnt`.
  - Sticky `ex_timeout` register.
  - 32-bit `stall_cnt`.
- `stall`, `flush`, `new_pc` and `ex_abort` are combinational from the current state and inputs. All other state is registered.
- Request priority, highest first: `flush_req` > watchdog expiry > execute wait > `stallreq_id`.
- Stall encodings:
  - Idle: 6'b000000.
  - Decode stall: 6'b000111. pc, if_id and decode hold; id_ex loads a bubble.
  - Execute stall: 6'b001111.
  - Flush: 6'b000000 with `flush`=1.
- RUN:
  - `flush_req` → flush output; remain RUN.
  - `ex_start` (no flush) → execute stall this cycle; next state EX_WAIT; `wait_cnt` ← 0.
  - Otherwise `stallreq_id` → decode stall.
  - `ex_done` in RUN is ignored.
- EX_WAIT:
  - Execute stall is asserted every cycle. `stallreq_id` is ignored.
  - `flush_req` → flush output and `ex_abort`=1; next state RUN.
  - `ex_done` (no flush) → stall released in the same cycle. Output is the decode stall if `stallreq_id`=1, else idle. Next state RUN.
  - Neither event and `wait_cnt` = `MAX_EX_CYCLES`-1 → `ex_abort`=1; execute stall is held this cycle; next state RUN; `ex_timeout` ← 1.
  - Otherwise `wait_cnt` increments.
  - `ex_start` in EX_WAIT is ignored (one outstanding operation only).
- `ex_done` and `flush_req` in the same EX_WAIT cycle: flush wins and `ex_abort`=1.
- `stall_cnt`:
  - Increments in every cycle where `stall[0]`=1.
  - Holds at 32'hFFFF_FFFF.
  - `cnt_clr` sets it to 0, overriding any increment in the same cycle.
- `ex_timeout` is cleared only by `rst`.

## Timing
- Reset (asynchronous, immediate):
  - State RUN; `wait_cnt`, `stall_cnt` and `ex_timeout` are 0.
  - `stall`, `flush`, `new_pc` and `ex_abort` are forced to 0 while `rst`=1, regardless of inputs.
- Zero-cycle latency from any request to `stall` or `flush`: requests are visible in the cycle they arrive.
- Execute stall duration:
  - With `ex_start` in cycle 0 and `ex_done` in cycle N (N≥1), `stall[3:0]`=4'b1111 in cycles 0..N-1 and is released in cycle N.
  - `stall_cnt` gains N.
- Watchdog with no `ex_done`:
  - EX_WAIT is entered after cycle 0.
  - `ex_abort` pulses in cycle `MAX_EX_CYCLES`.
  - `ex_timeout` rises at the end of that cycle. Total stalled cycles = `MAX_EX_CYCLES`+1.
- Flush always lasts exactly one cycle per `flush_req` pulse. Back-to-back pulses produce back-to-back flushes; `new_pc` tracks `flush_pc` each cycle.
- Reset asserted mid-EX_WAIT: the FSM returns to RUN immediately. No `ex_abort` is produced.

## Test plan
- Reset, then `stallreq_id`=1 for 3 cycles → `stall`=6'b000111 for exactly those 3 cycles; `stall_cnt`=3.
- `ex_start` at cycle 0, `ex_done` at cycle 5 → `stall`=6'b001111 in cycles 0–4 and 0 in cycle 5; `ex_abort` never asserted; `stall_cnt`=5.
- With `MAX_EX_CYCLES`=4, `ex_start` and no `ex_done` → `ex_abort` pulse in cycle 4; `ex_timeout`=1 from cycle 5 and it persists until `rst`; `stall_cnt`=5.
- In EX_WAIT, `flush_req` and `ex_done` in the same cycle with `flush_pc`=32'h0000_0100 → in that cycle `flush`=1, `new_pc`=32'h100, `stall`=0, `ex_abort`=1; FSM is RUN next cycle.
- `ex_done` and `stallreq_id` together in EX_WAIT → `stall`=6'b000111 in that cycle; RUN next cycle.
- `stall_cnt` preloaded to 32'hFFFF_FFFE, then 3 stall cycles → value saturates at 32'hFFFF_FFFF; `cnt_clr` with a concurrent stall → 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges decode/execute stall requests and flushes into a
// per-stage stall vector, guards multi-cycle execute ops with a watchdog, counts stall cycles.
module pipe_ctrl #(
    parameter int unsigned MAX_EX_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        ex_start,
    input  logic        ex_done,
    input  logic        flush_req,
    input  logic [31:0] flush_pc,
    input  logic        cnt_clr,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        ex_abort,
    output logic        ex_timeout,
    output logic [31:0] stall_cnt
);

    typedef enum logic {StRun, StExWait} state_e;

    localparam logic [5:0]  StallIdle = 6'b000000;
    localparam logic [5:0]  StallId   = 6'b000111;
    localparam logic [5:0]  StallEx   = 6'b001111;
    localparam logic [15:0] WaitLast  = 16'(MAX_EX_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        stall      = StallIdle;
        flush      = 1'b0;
        new_pc     = 32'h0;
        ex_abort   = 1'b0;

        unique case (state_q)
            StRun: begin
                if (flush_req) begin
                    flush  = 1'b1;
                    new_pc = flush_pc;
                end else if (ex_start) begin
                    stall      = StallEx;
                    state_d    = StExWait;
                    wait_cnt_d = 16'h0;
                end else if (stallreq_id) begin
                    stall = StallId;
                end
            end
            StExWait: begin
                if (flush_req) begin
                    flush    = 1'b1;
                    new_pc   = flush_pc;
                    ex_abort = 1'b1;
                    state_d  = StRun;
                end else if (ex_done) begin
                    // Result is ready this cycle, so the hold is released immediately.
                    stall   = stallreq_id ? StallId : StallIdle;
                    state_d = StRun;
                end else if (wait_cnt_q == WaitLast) begin
                    stall     = StallEx;
                    ex_abort  = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = StRun;
                end else begin
                    stall      = StallEx;
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            default: state_d = StRun;
        endcase

        if (rst) begin
            stall    = StallIdle;
            flush    = 1'b0;
            new_pc   = 32'h0;
            ex_abort = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = 32'h0;
        end else if (stall[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            wait_cnt_q  <= 16'h0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_timeout = timeout_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes model predictions, a negedge monitor
// pops and compares against the DUT outputs every cycle.
module tb_pipe_ctrl;

    localparam int unsigned MAXC = 4;

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        ex_abort;
        logic        ex_timeout;
        logic [31:0] stall_cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_id = 1'b0;
    logic        ex_start = 1'b0;
    logic        ex_done = 1'b0;
    logic        flush_req = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        cnt_clr = 1'b0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        ex_abort;
    logic        ex_timeout;
    logic [31:0] stall_cnt;

    pipe_ctrl #(.MAX_EX_CYCLES(MAXC)) dut (
        .clk        (clk),
        .rst        (rst),
        .stallreq_id(stallreq_id),
        .ex_start   (ex_start),
        .ex_done    (ex_done),
        .flush_req  (flush_req),
        .flush_pc   (flush_pc),
        .cnt_clr    (cnt_clr),
        .stall      (stall),
        .flush      (flush),
        .new_pc     (new_pc),
        .ex_abort   (ex_abort),
        .ex_timeout (ex_timeout),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference model: an outstanding op and how many cycles it has been waiting.
    bit          m_busy = 1'b0;
    int unsigned m_age  = 0;
    bit          m_to   = 1'b0;
    logic [31:0] m_cnt  = 32'h0;

    task automatic step(input bit r, input bit sid, input bit es, input bit ed,
                        input bit fr, input logic [31:0] fpc, input bit clr);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; stallreq_id = sid; ex_start = es; ex_done = ed;
        flush_req = fr; flush_pc = fpc; cnt_clr = clr;
        e = '0;
        if (r) begin
            m_busy = 1'b0; m_age = 0; m_to = 1'b0; m_cnt = 32'h0;
            exp_q.push_back(e);
            return;
        end
        e.ex_timeout = m_to;
        e.stall_cnt  = m_cnt;
        if (!m_busy) begin
            if (fr) begin
                e.flush = 1'b1; e.new_pc = fpc;
            end else if (es) begin
                e.stall = 6'b001111; m_busy = 1'b1; m_age = 1;
            end else if (sid) begin
                e.stall = 6'b000111;
            end
        end else begin
            if (fr) begin
                e.flush = 1'b1; e.new_pc = fpc; e.ex_abort = 1'b1; m_busy = 1'b0;
            end else if (ed) begin
                e.stall = sid ? 6'b000111 : 6'b000000; m_busy = 1'b0;
            end else if (m_age == MAXC) begin
                e.stall = 6'b001111; e.ex_abort = 1'b1; m_busy = 1'b0; m_to = 1'b1;
            end else begin
                e.stall = 6'b001111; m_age++;
            end
        end
        if (clr) m_cnt = 32'h0;
        else if (e.stall[0] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e, a;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{stall, flush, new_pc, ex_abort, ex_timeout, stall_cnt};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle %0d: got stall=%b flush=%b new_pc=%h abort=%b tmo=%b cnt=%h, expected stall=%b flush=%b new_pc=%h abort=%b tmo=%b cnt=%h",
                         cyc, a.stall, a.flush, a.new_pc, a.ex_abort, a.ex_timeout,
                         a.stall_cnt, e.stall, e.flush, e.new_pc, e.ex_abort,
                         e.ex_timeout, e.stall_cnt);
            end
        end
    end

    initial begin
        step(1, 1, 1, 1, 1, 32'hDEAD_BEEF, 0);
        step(1, 0, 0, 0, 0, 32'h0, 0);
        idle(1);
        // Decode stall for three cycles.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 32'h0, 0);
        idle(2);
        // ex_start in cycle 0, ex_done in cycle 5.
        step(0, 0, 1, 0, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 1, 0, 32'h0, 0);
        idle(2);
        // Watchdog expiry, then ex_timeout stays sticky.
        step(0, 0, 1, 0, 0, 32'h0, 0);
        idle(MAXC + 4);
        // Flush together with ex_done while waiting.
        step(0, 0, 1, 0, 0, 32'h0, 0);
        step(0, 0, 0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 1, 1, 32'h0000_0100, 0);
        idle(1);
        // ex_done together with stallreq_id while waiting.
        step(0, 0, 1, 0, 0, 32'h0, 0);
        step(0, 1, 0, 1, 0, 32'h0, 0);
        idle(1);
        // Back-to-back flushes, ignored ex_start in EX_WAIT.
        step(0, 0, 0, 0, 1, 32'h1111_0000, 0);
        step(0, 0, 0, 0, 1, 32'h2222_0004, 0);
        step(0, 0, 1, 0, 0, 32'h0, 0);
        step(0, 0, 1, 0, 0, 32'h0, 0);
        step(0, 0, 0, 1, 0, 32'h0, 0);
        // Reset in the middle of EX_WAIT.
        step(0, 0, 1, 0, 0, 32'h0, 0);
        step(0, 0, 0, 0, 0, 32'h0, 0);
        step(1, 0, 0, 0, 0, 32'h0, 0);
        idle(2);
        // Saturation: preload the counter just below its ceiling.
        @(negedge clk);
        #1;
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 32'h0, 0);
        step(0, 1, 0, 0, 0, 32'h0, 1);
        idle(2);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 40) == 0));
        end
        idle(1);
        @(posedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
